// File: rtl/lfsr_hex_gen_pkg.sv
// Shared constants for the LFSR pattern generator: 7-segment code table,
// blank pattern and the default 8-bit feedback mask.
package lfsr_hex_gen_pkg;

    // Active-low 7-segment codes, bit7..1 = a..g, bit0 = dp (kept dark).
    localparam logic [7:0] SEG7_HEX [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D,
        8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1,
        8'h63, 8'h85, 8'h61, 8'h71
    };

    // All segments and the decimal point off.
    localparam logic [7:0] SEG7_BLANK = 8'hFF;

    // Maximal-length feedback mask for the 8-bit default configuration.
    localparam logic [7:0] LFSR_TAPS_8 = 8'h1D;

    // Look up the active-low segment pattern for one hex nibble.
    function automatic logic [7:0] seg7_code(input logic [3:0] nibble);
        return SEG7_HEX[nibble];
    endfunction

endpackage

// File: rtl/lfsr_hex_gen_hex_to_seg7.sv
// One hex digit decoder: 4-bit nibble to active-low 7-segment pattern.
module hex_to_seg7
    import lfsr_hex_gen_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg_n
);

    // Pure table lookup, the decimal point is never lit.
    always_comb begin
        seg_n = seg7_code(nibble);
    end

endmodule

// File: rtl/lfsr_hex_gen.sv
// Fibonacci LFSR pattern generator for board demos. Steps on a switch edge
// or on a prescaled tick, loads a seed with zero-lockup substitution,
// measures the sequence period and shows the state on hex 7-seg digits.
module lfsr_hex_gen
    import lfsr_hex_gen_pkg::*;
#(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(LFSR_TAPS_8),
    parameter int              DIV_W      = 24,
    localparam int             NUM_DIGITS = (WIDTH + 3) / 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sw_step,
    input  logic                    sw_load,
    input  logic                    sw_run,
    input  logic [WIDTH-1:0]        seed,
    output logic [WIDTH-1:0]        lfsr_q,
    output logic                    zero_flag,
    output logic                    seed_fixed,
    output logic [WIDTH-1:0]        period_len,
    output logic                    period_valid,
    output logic [8*NUM_DIGITS-1:0] seg_n
);

    localparam int PAD_W = 4 * NUM_DIGITS;

    logic [2:0]         step_sync;
    logic [2:0]         load_sync;
    logic [1:0]         run_sync;
    logic               step_pulse;
    logic               load_pulse;
    logic               run_s;
    logic [DIV_W-1:0]   prescaler;
    logic               tick;
    logic               step_en;
    logic               feedback;
    logic [WIDTH-1:0]   lfsr_next;
    logic [WIDTH-1:0]   seed_safe;
    logic [WIDTH-1:0]   seed_reg;
    logic [WIDTH-1:0]   cnt;
    logic [PAD_W-1:0]   hex_value;

    // Bring the asynchronous switches into the clock domain; the third stage
    // of the edge chains holds the previous synced value for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_sync <= '0;
            load_sync <= '0;
            run_sync  <= '0;
        end else begin
            step_sync <= {step_sync[1:0], sw_step};
            load_sync <= {load_sync[1:0], sw_load};
            run_sync  <= {run_sync[0], sw_run};
        end
    end

    // Rising-edge pulses, free-run level and the step selection.
    always_comb begin
        step_pulse = step_sync[1] & ~step_sync[2];
        load_pulse = load_sync[1] & ~load_sync[2];
        run_s      = run_sync[1];
        tick       = run_s & (&prescaler);
        step_en    = run_s ? tick : step_pulse;
    end

    // Free-running prescaler; held at zero when not running so every run
    // starts with a full period before the first step.
    always_ff @(posedge clk) begin
        if (rst || load_pulse || !run_s) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + DIV_W'(1);
        end
    end

    // Next LFSR state and the zero-safe seed.
    always_comb begin
        feedback  = ^(lfsr_q & TAPS);
        lfsr_next = {feedback, lfsr_q[WIDTH-1:1]};
        seed_safe = (seed == '0) ? WIDTH'(1) : seed;
    end

    // LFSR state, seed capture and period measurement; a load wins over a
    // step arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q       <= WIDTH'(1);
            seed_reg     <= WIDTH'(1);
            seed_fixed   <= 1'b0;
            cnt          <= '0;
            period_len   <= '0;
            period_valid <= 1'b0;
        end else if (load_pulse) begin
            lfsr_q       <= seed_safe;
            seed_reg     <= seed_safe;
            seed_fixed   <= (seed == '0);
            cnt          <= '0;
            period_valid <= 1'b0;
        end else if (step_en) begin
            lfsr_q <= lfsr_next;
            if (lfsr_next == seed_reg) begin
                period_len   <= cnt + WIDTH'(1);
                period_valid <= 1'b1;
                cnt          <= '0;
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

    // Safety flag and zero-extended display value derived from the state.
    always_comb begin
        zero_flag = (lfsr_q == '0);
        hex_value = PAD_W'(lfsr_q);
    end

    genvar k;
    generate
        for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
            hex_to_seg7 u_digit (
                .nibble (hex_value[4*k +: 4]),
                .seg_n  (seg_n[8*k +: 8])
            );
        end
    endgenerate

endmodule

// File: tb/tb_lfsr_hex_gen.sv
// Directed bench for lfsr_hex_gen: an 8-bit instance with a short prescaler
// and a 12-bit instance for the multi-digit display.
module tb_lfsr_hex_gen;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        sw_step, sw_load, sw_run;
    logic [7:0]  seed8;
    logic [7:0]  lfsr8, period_len8;
    logic        zero_flag8, seed_fixed8, period_valid8;
    logic [15:0] seg8;

    logic        sw_step12, sw_load12, sw_run12;
    logic [11:0] seed12;
    logic [11:0] lfsr12, period_len12;
    logic        zero_flag12, seed_fixed12, period_valid12;
    logic [23:0] seg12;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cycles;
    logic [31:0] model_state;
    logic [7:0]  step_table [5];

    always #5 clk = ~clk;

    lfsr_hex_gen #(.WIDTH(8), .TAPS(8'h1D), .DIV_W(2)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .sw_step      (sw_step),
        .sw_load      (sw_load),
        .sw_run       (sw_run),
        .seed         (seed8),
        .lfsr_q       (lfsr8),
        .zero_flag    (zero_flag8),
        .seed_fixed   (seed_fixed8),
        .period_len   (period_len8),
        .period_valid (period_valid8),
        .seg_n        (seg8)
    );

    lfsr_hex_gen #(.WIDTH(12), .TAPS(12'h829), .DIV_W(2)) dut12 (
        .clk          (clk),
        .rst          (rst),
        .sw_step      (sw_step12),
        .sw_load      (sw_load12),
        .sw_run       (sw_run12),
        .seed         (seed12),
        .lfsr_q       (lfsr12),
        .zero_flag    (zero_flag12),
        .seed_fixed   (seed_fixed12),
        .period_len   (period_len12),
        .period_valid (period_valid12),
        .seg_n        (seg12)
    );

    // Reference Fibonacci step for a w-bit register.
    function automatic logic [31:0] lfsr_model(input logic [31:0] s,
                                               input logic [31:0] taps,
                                               input int w);
        logic fb;
        fb = ^(s & taps);
        return (s >> 1) | (32'(fb) << (w - 1));
    endfunction

    // Raise the chosen switches, queue the expected state and wait until the
    // edge has propagated (3 clk), ending on a falling edge.
    task automatic applyStimulus(input int sel, input logic do_step,
                                 input logic do_load, input logic [31:0] seed_val,
                                 input string tag, input logic [31:0] expected);
        exp_t e;
        @(negedge clk);
        if (sel == 0) begin
            seed8   = seed_val[7:0];
            sw_step = do_step;
            sw_load = do_load;
        end else begin
            seed12    = seed_val[11:0];
            sw_step12 = do_step;
            sw_load12 = do_load;
        end
        e.tag   = tag;
        e.value = expected;
        sb_q.push_back(e);
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    // Drop all manual switches and let the synchronisers settle.
    task automatic releaseSwitches();
        sw_step   = 1'b0;
        sw_load   = 1'b0;
        sw_step12 = 1'b0;
        sw_load12 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    // Pop the oldest expected state and compare it with the observed one.
    task automatic checkOutput(input logic [31:0] observed);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed %h with nothing expected", observed);
        end else begin
            e = sb_q.pop_front();
            assert (observed === e.value) else begin
                errors++;
                $error("[TB] FAIL %s: observed %h expected %h", e.tag, observed, e.value);
            end
        end
    endtask

    // Direct comparison for flags, display and timing values.
    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        step_table[0] = 8'h80;
        step_table[1] = 8'h40;
        step_table[2] = 8'h20;
        step_table[3] = 8'h10;
        step_table[4] = 8'h88;

        rst       = 1'b1;
        sw_step   = 1'b0;
        sw_load   = 1'b0;
        sw_run    = 1'b0;
        seed8     = 8'h00;
        sw_step12 = 1'b0;
        sw_load12 = 1'b0;
        sw_run12  = 1'b0;
        seed12    = 12'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("[TB] reset state");
        checkValue("rst_lfsr", lfsr8, 32'h01);
        checkValue("rst_zero_flag", zero_flag8, 32'h0);
        checkValue("rst_seed_fixed", seed_fixed8, 32'h0);
        checkValue("rst_period_valid", period_valid8, 32'h0);
        checkValue("rst_period_len", period_len8, 32'h0);
        checkValue("rst_seg", seg8, 32'h039F);
        checkValue("rst_seg12", seg12, 32'h03039F);
        rst = 1'b0;

        $display("[TB] load 0x01 and manual steps");
        applyStimulus(0, 1'b0, 1'b1, 32'h01, "load_01", 32'h01);
        checkOutput(lfsr8);
        releaseSwitches();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 32'h01, $sformatf("step_%0d", i),
                          32'(step_table[i]));
            checkOutput(lfsr8);
            if (i == 0) checkValue("seg_after_first", seg8, 32'h0103);
            releaseSwitches();
        end
        checkValue("no_step_on_release", lfsr8, 32'h88);

        $display("[TB] zero seed substitution");
        applyStimulus(0, 1'b0, 1'b1, 32'h00, "load_zero", 32'h01);
        checkOutput(lfsr8);
        checkValue("seed_fixed_set", seed_fixed8, 32'h1);
        checkValue("zero_flag_after_fix", zero_flag8, 32'h0);
        releaseSwitches();
        applyStimulus(0, 1'b0, 1'b1, 32'h5A, "load_5a", 32'h5A);
        checkOutput(lfsr8);
        checkValue("seed_fixed_clear", seed_fixed8, 32'h0);
        checkValue("seg_5a", seg8, 32'h4911);
        releaseSwitches();

        $display("[TB] load and step in the same cycle");
        applyStimulus(0, 1'b1, 1'b1, 32'h33, "load_step_33", 32'h33);
        checkOutput(lfsr8);
        releaseSwitches();
        checkValue("load_step_hold", lfsr8, 32'h33);
        checkValue("load_step_pvalid", period_valid8, 32'h0);

        $display("[TB] free-run period measurement");
        applyStimulus(0, 1'b0, 1'b1, 32'h01, "load_run", 32'h01);
        checkOutput(lfsr8);
        releaseSwitches();
        sw_run = 1'b1;
        cycles = 0;
        while (period_valid8 !== 1'b1 && cycles < 3000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        checkValue("period_valid_seen", period_valid8, 32'h1);
        checkValue("period_cycles", cycles, 32'd1022);
        checkValue("period_len", period_len8, 32'd255);
        checkValue("period_lfsr", lfsr8, 32'h01);

        $display("[TB] reset while running");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkValue("midrun_rst_lfsr", lfsr8, 32'h01);
        checkValue("midrun_rst_pvalid", period_valid8, 32'h0);
        checkValue("midrun_rst_plen", period_len8, 32'h0);
        rst = 1'b0;

        $display("[TB] step switch ignored while running");
        model_state = 32'h01;
        for (int i = 0; i < 10; i++) model_state = lfsr_model(model_state, 32'h1D, 8);
        begin
            exp_t e;
            e.tag   = "run_ten_ticks";
            e.value = model_state;
            sb_q.push_back(e);
        end
        for (int i = 0; i < 42; i++) begin
            if (i % 3 == 0) sw_step = ~sw_step;
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput(lfsr8);
        sw_run  = 1'b0;
        sw_step = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkValue("run_stop_hold", lfsr8, model_state);
        checkValue("run_pvalid_low", period_valid8, 32'h0);

        $display("[TB] 12-bit instance");
        applyStimulus(1, 1'b0, 1'b1, 32'hABC, "load_abc", 32'hABC);
        checkOutput(lfsr12);
        checkValue("seg12_abc", seg12, 32'h11C163);
        releaseSwitches();
        applyStimulus(1, 1'b1, 1'b0, 32'hABC, "step12",
                      lfsr_model(32'hABC, 32'h829, 12));
        checkOutput(lfsr12);
        checkValue("step12_literal", lfsr12, 32'hD5E);
        releaseSwitches();

        checkValue("scoreboard_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
